stack_cmd_sequencer: RTL and testbench

//  Upstream command sequencer for the stack unit. Accepts stack commands on a valid/ready port
//  and buffers them in a small FIFO. Issues them one at a time on the stack's level-transition
//  (toggle) handshake. Captures each result and presents it downstream on a valid/ready port.

---
 rtl/stack_cmd_sequencer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_stack_cmd_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// stack_cmd_sequencer
//
// Upstream command sequencer for the STACK unit. Commands arrive on a
// valid/ready port and are buffered in a small FIFO. They are issued to STACK
// one at a time using its level-transition handshake: rdy_out toggles once per
// request, and the request is complete when ack_in equals rdy_out. Each result
// is captured and offered downstream on a valid/ready port. This block does no
// arithmetic. Data passes through unmodified as a signed 32-bit value.
//
// Parameters
//   FIFO_DEPTH   command FIFO entries (power of 2, >= 2)
//   TIMEOUT_CYC  cycles to wait for an ack toggle before halting (>= 2)
//
// Ports
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     upstream command handshake (ready = FIFO not full)
//   cmd_op/cmd_data/cmd_n   command fields: op 0..4 legal, data = PUSH operand,
//                           n = MEAN element count
//   rdy_out                 request toggle to STACK rdy_in
//   op_out/datain_out/n_out request fields to STACK; they change only on a pop
//   ack_in                  STACK ack; the request is done when ack_in == rdy_out
//   dataout_in/esito_in     STACK result and status, valid when the ack matches
//   res_valid/res_ready     downstream result handshake
//   res_data/res_esito/res_op  captured result, status and originating op
//   busy                    FSM not idle, or FIFO non-empty
//   timeout_err             sticky timeout flag, cleared only by reset
//   fifo_level              current FIFO occupancy
// -----------------------------------------------------------------------------
module stack_cmd_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [31:0]                   cmd_data,
    input  logic [9:0]                    cmd_n,
    output logic                          rdy_out,
    output logic [2:0]                    op_out,
    output logic [31:0]                   datain_out,
    output logic [9:0]                    n_out,
    input  logic                          ack_in,
    input  logic [31:0]                   dataout_in,
    input  logic                          esito_in,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [31:0]                   res_data,
    output logic                          res_esito,
    output logic [2:0]                    res_op,
    output logic                          busy,
    output logic                          timeout_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int EW = 3 + 32 + 10;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [2:0]    OP_MEAN    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESULT = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    // FIFO storage and bookkeeping
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    // FSM and request/result registers
    state_e        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [31:0]   data_q, data_d;
    logic [9:0]    n_q, n_d;
    logic          rdy_q, rdy_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          res_valid_q, res_valid_d;
    logic [31:0]   res_data_q, res_data_d;
    logic          res_esito_q, res_esito_d;
    logic [2:0]    res_op_q, res_op_d;
    logic          timeout_q, timeout_d;

    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          cmd_ready_s;
    logic          push_s;
    logic          pop_s;
    logic [EW-1:0] head_s;
    logic [2:0]    head_op_s;
    logic [31:0]   head_data_s;
    logic [9:0]    head_n_s;
    logic          head_reject_s;

    assign fifo_full_s  = (level_q == LEVEL_FULL);
    assign fifo_empty_s = (level_q == {LW{1'b0}});
    // HALT stops intake so nothing piles up behind a dead STACK.
    assign cmd_ready_s  = !fifo_full_s && (state_q != ST_HALT);
    assign push_s       = cmd_valid && cmd_ready_s;
    // Pops happen only from IDLE, which also guarantees one request outstanding.
    assign pop_s        = (state_q == ST_IDLE) && !fifo_empty_s;

    assign head_s        = mem_q[rd_ptr_q];
    assign head_op_s     = head_s[44:42];
    assign head_data_s   = head_s[41:10];
    assign head_n_s      = head_s[9:0];
    // Illegal opcodes and an empty MEAN are answered locally without touching STACK.
    assign head_reject_s = (head_op_s > OP_MEAN) ||
                           ((head_op_s == OP_MEAN) && (head_n_s == 10'd0));

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO storage write port
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {EW{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_data, cmd_n};
        end
    end

    // Sequencer FSM next-state and register updates
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        n_d         = n_q;
        rdy_d       = rdy_q;
        timer_d     = timer_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_esito_d = res_esito_q;
        res_op_d    = res_op_q;
        timeout_d   = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    op_d   = head_op_s;
                    data_d = head_data_s;
                    n_d    = head_n_s;
                    if (head_reject_s) begin
                        res_data_d  = 32'd0;
                        res_esito_d = 1'b0;
                        res_op_d    = head_op_s;
                        res_valid_d = 1'b1;
                        state_d     = ST_RESULT;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                rdy_d   = ~rdy_q;
                timer_d = {TW{1'b0}};
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ack_in == rdy_q) begin
                    res_data_d  = dataout_in;
                    res_esito_d = esito_in;
                    res_op_d    = op_q;
                    res_valid_d = 1'b1;
                    state_d     = ST_RESULT;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESULT;
                end
            end
            ST_HALT: begin
                res_valid_d = 1'b0;
                state_d     = ST_HALT;
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            level_q     <= {LW{1'b0}};
            state_q     <= ST_IDLE;
            op_q        <= 3'd0;
            data_q      <= 32'd0;
            n_q         <= 10'd0;
            rdy_q       <= 1'b0;
            timer_q     <= {TW{1'b0}};
            res_valid_q <= 1'b0;
            res_data_q  <= 32'd0;
            res_esito_q <= 1'b0;
            res_op_q    <= 3'd0;
            timeout_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            n_q         <= n_d;
            rdy_q       <= rdy_d;
            timer_q     <= timer_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_esito_q <= res_esito_d;
            res_op_q    <= res_op_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_s;
    assign rdy_out     = rdy_q;
    assign op_out      = op_q;
    assign datain_out  = data_q;
    assign n_out       = n_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_esito   = res_esito_q;
    assign res_op      = res_op_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty_s;
    assign timeout_err = timeout_q;
    assign fifo_level  = level_q;

endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stack_cmd_sequencer
//
// Directed bench for stack_cmd_sequencer. A behavioural STACK stub answers each
// rdy_out toggle after a short delay. Results are collected by a monitor and
// compared against hand-computed values.
// -----------------------------------------------------------------------------
module tb_stack_cmd_sequencer;

    logic        clock;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_data;
    logic [9:0]  cmd_n;
    logic        rdy_out;
    logic [2:0]  op_out;
    logic [31:0] datain_out;
    logic [9:0]  n_out;
    logic        ack_in;
    logic [31:0] dataout_in;
    logic        esito_in;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_esito;
    logic [2:0]  res_op;
    logic        busy;
    logic        timeout_err;
    logic [2:0]  fifo_level;

    int n_checks = 0;
    int n_errors = 0;

    stack_cmd_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYC(1024)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_n(cmd_n),
        .rdy_out(rdy_out), .op_out(op_out), .datain_out(datain_out), .n_out(n_out),
        .ack_in(ack_in), .dataout_in(dataout_in), .esito_in(esito_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_esito(res_esito), .res_op(res_op),
        .busy(busy), .timeout_err(timeout_err), .fifo_level(fifo_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Check helper: every comparison in the bench goes through here
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // STACK stub: 8-deep integer stack, answers 3 cycles after a toggle
    logic stub_en;
    int   stk [8];
    int   sp;
    int   dly;
    logic [31:0] r_data;
    logic        r_ok;

    task automatic stack_exec(input logic [2:0] op, input logic [31:0] d, input logic [9:0] n,
                              output logic [31:0] rd, output logic ok);
        longint s;
        rd = 32'd0;
        ok = 1'b0;
        case (op)
            3'd0: if (sp < 8) begin stk[sp] = int'(d); sp = sp + 1; rd = d; ok = 1'b1; end
            3'd1: if (sp > 0) begin sp = sp - 1; rd = stk[sp]; ok = 1'b1; end
            3'd2: if (sp > 1) begin rd = stk[sp-2] + stk[sp-1]; sp = sp - 2; ok = 1'b1; end
            3'd3: if (sp > 1) begin rd = stk[sp-2] - stk[sp-1]; sp = sp - 2; ok = 1'b1; end
            3'd4: if (n != 10'd0 && sp >= int'(n)) begin
                      s = 0;
                      for (int i = 0; i < int'(n); i++) s = s + longint'(stk[sp-1-i]);
                      rd = 32'(s / longint'(n));
                      sp = sp - int'(n);
                      ok = 1'b1;
                  end
            default: ok = 1'b0;
        endcase
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ack_in     <= 1'b0;
            dataout_in <= 32'd0;
            esito_in   <= 1'b0;
            sp = 0;
            dly = 0;
        end else if (stub_en && (rdy_out != ack_in)) begin
            if (dly < 2) begin
                dly = dly + 1;
            end else begin
                dly = 0;
                stack_exec(op_out, datain_out, n_out, r_data, r_ok);
                dataout_in <= r_data;
                esito_in   <= r_ok;
                ack_in     <= rdy_out;
            end
        end
    end

    // Result monitor and rdy_out toggle counter
    logic [31:0] rq_data [$];
    logic        rq_esito [$];
    logic [2:0]  rq_op [$];
    int          toggles = 0;

    always @(posedge clock) begin
        if (reset_n && res_valid && res_ready) begin
            rq_data.push_back(res_data);
            rq_esito.push_back(res_esito);
            rq_op.push_back(res_op);
        end
    end

    always @(rdy_out) toggles++;

    task automatic do_reset();
        @(negedge clock);
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        rq_data.delete();
        rq_esito.delete();
        rq_op.delete();
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [31:0] d, input logic [9:0] n);
        int t;
        t = 0;
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_n     = n;
        while (!cmd_ready && t < 2000) begin
            @(negedge clock);
            t++;
        end
        if (!cmd_ready) begin
            check_eq("send_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_results(input int n, input string tag);
        int t;
        t = 0;
        while (rq_data.size() < n && t < 2000) begin
            @(negedge clock);
            t++;
        end
        check_eq(tag, 32'(rq_data.size()), 32'(n));
    endtask

    task automatic check_res(input int idx, input logic [31:0] d, input logic ok, input logic [2:0] op);
        if (idx < rq_data.size()) begin
            check_eq($sformatf("res%0d_data", idx), rq_data[idx], d);
            check_eq($sformatf("res%0d_esito", idx), 32'(rq_esito[idx]), 32'(ok));
            check_eq($sformatf("res%0d_op", idx), 32'(rq_op[idx]), 32'(op));
        end else begin
            check_eq($sformatf("res%0d_missing", idx), 32'(rq_data.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int toggles0;
    int cyc;

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 32'd0;
        cmd_n     = 10'd0;
        res_ready = 1'b1;
        stub_en   = 1'b1;
        repeat (2) @(negedge clock);

        // Reset state
        check_eq("rst_rdy_out", 32'(rdy_out), 32'd0);
        check_eq("rst_res_valid", 32'(res_valid), 32'd0);
        check_eq("rst_res_data", res_data, 32'd0);
        check_eq("rst_timeout", 32'(timeout_err), 32'd0);
        check_eq("rst_level", 32'(fifo_level), 32'd0);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;

        // Test 1: single PUSH, with pop/toggle latency
        do_reset();
        send_cmd(3'd0, 32'd1023, 10'd0);
        check_eq("t1_level_after_push", 32'(fifo_level), 32'd1);
        check_eq("t1_rdy_k", 32'(rdy_out), 32'd0);
        @(posedge clock); #1;
        check_eq("t1_level_after_pop", 32'(fifo_level), 32'd0);
        check_eq("t1_datain_out", datain_out, 32'd1023);
        check_eq("t1_rdy_k1", 32'(rdy_out), 32'd0);
        @(posedge clock); #1;
        check_eq("t1_rdy_k2", 32'(rdy_out), 32'd1);
        wait_results(1, "t1_count");
        check_res(0, 32'd1023, 1'b1, 3'd0);

        // Test 2: back-to-back PUSH, PUSH, SUM
        do_reset();
        send_cmd(3'd0, 32'd500, 10'd0);
        send_cmd(3'd0, 32'd750, 10'd0);
        send_cmd(3'd2, 32'd0, 10'd0);
        wait_results(3, "t2_count");
        check_res(0, 32'd500, 1'b1, 3'd0);
        check_res(1, 32'd750, 1'b1, 3'd0);
        check_res(2, 32'd1250, 1'b1, 3'd2);

        // Test 3: MEAN of four values, then POP on the emptied stack
        do_reset();
        send_cmd(3'd0, 32'd1200, 10'd0);
        send_cmd(3'd0, 32'd300, 10'd0);
        send_cmd(3'd0, 32'd750, 10'd0);
        send_cmd(3'd0, 32'd500, 10'd0);
        send_cmd(3'd4, 32'd0, 10'd4);
        send_cmd(3'd1, 32'd0, 10'd0);
        wait_results(6, "t3_count");
        check_res(4, 32'd687, 1'b1, 3'd4);
        check_res(5, 32'd0, 1'b0, 3'd1);

        // Test 4: backpressure fills the FIFO, then drains in order
        do_reset();
        res_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++) send_cmd(3'd0, 32'(11 * i), 10'd0);
            end
            begin
                repeat (40) @(negedge clock);
                check_eq("t4_level_full", 32'(fifo_level), 32'd4);
                check_eq("t4_cmd_ready", 32'(cmd_ready), 32'd0);
                check_eq("t4_res_valid_held", 32'(res_valid), 32'd1);
                check_eq("t4_res_data_held", res_data, 32'd11);
                check_eq("t4_no_results_yet", 32'(rq_data.size()), 32'd0);
                res_ready = 1'b1;
            end
        join
        wait_results(6, "t4_count");
        for (int i = 0; i < 6; i++) check_res(i, 32'(11 * (i + 1)), 1'b1, 3'd0);

        // Test 5: local rejects never reach STACK
        do_reset();
        toggles0 = toggles;
        send_cmd(3'd5, 32'd99, 10'd3);
        send_cmd(3'd4, 32'd77, 10'd0);
        send_cmd(3'd7, 32'd55, 10'd1);
        wait_results(3, "t5_count");
        check_res(0, 32'd0, 1'b0, 3'd5);
        check_res(1, 32'd0, 1'b0, 3'd4);
        check_res(2, 32'd0, 1'b0, 3'd7);
        check_eq("t5_no_toggle", 32'(toggles - toggles0), 32'd0);
        check_eq("t5_rdy_out", 32'(rdy_out), 32'd0);

        // Test 6: STACK never acks -> timeout after 1024 cycles in WAIT, then HALT
        do_reset();
        stub_en = 1'b0;
        send_cmd(3'd0, 32'd5, 10'd0);
        cyc = 0;
        while (!timeout_err && cyc < 1200) begin
            @(posedge clock); #1;
            cyc++;
        end
        check_eq("t6_timeout_err", 32'(timeout_err), 32'd1);
        check_eq("t6_timeout_cycles", 32'(cyc), 32'd1026);
        check_eq("t6_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("t6_res_valid", 32'(res_valid), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd1);
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_data  = 32'd9;
        repeat (5) @(negedge clock);
        cmd_valid = 1'b0;
        check_eq("t6_halt_no_push", 32'(fifo_level), 32'd0);
        check_eq("t6_rdy_frozen", 32'(rdy_out), 32'd1);
        check_eq("t6_sticky", 32'(timeout_err), 32'd1);

        // Async reset mid-WAIT abandons the request
        do_reset();
        send_cmd(3'd0, 32'd7, 10'd0);
        repeat (10) @(posedge clock);
        #1;
        check_eq("t6_wait_busy", 32'(busy), 32'd1);
        check_eq("t6_wait_rdy", 32'(rdy_out), 32'd1);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t6_arst_rdy", 32'(rdy_out), 32'd0);
        check_eq("t6_arst_busy", 32'(busy), 32'd0);
        check_eq("t6_arst_level", 32'(fifo_level), 32'd0);
        check_eq("t6_arst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("t6_arst_datain", datain_out, 32'd0);
        check_eq("t6_arst_timeout", 32'(timeout_err), 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        stub_en = 1'b1;
        rq_data.delete();
        rq_esito.delete();
        rq_op.delete();
        repeat (20) @(negedge clock);
        check_eq("t6_no_stale_result", 32'(rq_data.size()), 32'd0);
        send_cmd(3'd0, 32'd42, 10'd0);
        wait_results(1, "t6_recover_count");
        check_res(0, 32'd42, 1'b1, 3'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
